// File: rtl/key_bit_collector.sv
// key_bit_collector
// -----------------------------------------------------------------------------
// Collects the serial output of the key chip. The block watches the host bus
// for qualified key-window read cycles (SSER_n=0, BA13=0, BA12=1, BR_W=1). It
// samples SDRD a fixed number of clocks after each cycle starts. The bits are
// packed MSB-first into bytes. Each completed byte goes to the host through a
// 2-entry valid/ready buffer.
//
// Parameters
//   SAMPLE_DLY  clocks from the detected strobe edge to the SDRD sample (1..15)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   bus_strobe  asynchronous bus-cycle strobe, active high
//   SSER_n      key-chip select, active low
//   BA13, BA12  bus address bits
//   BR_W        bus read/write, 1 = read
//   SDRD        key-chip serial data bit
//   clr         synchronous clear of all collector state
//   out_data    oldest completed byte
//   out_valid   out_data holds a byte
//   out_ready   consumer accepts out_data
//   bit_count   bits already shifted into the current partial byte
//   overflow    sticky: a completed byte was dropped because the buffer was full
//   collide     sticky: a qualified edge arrived while a sample was pending
// -----------------------------------------------------------------------------
module key_bit_collector #(
  parameter int SAMPLE_DLY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bus_strobe,
  input  logic       SSER_n,
  input  logic       BA13,
  input  logic       BA12,
  input  logic       BR_W,
  input  logic       SDRD,
  input  logic       clr,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] bit_count,
  output logic       overflow,
  output logic       collide
);

  localparam logic [3:0] DLY_LOAD = 4'(SAMPLE_DLY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2
  } state_t;

  // Strobe synchronizer and edge detector
  logic sync_p0;
  logic sync_p1;
  logic sync_p2;
  logic strobe_evt;
  logic qual_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= bus_strobe;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  // The qualifiers are stable while the strobe is high. They can therefore
  // be used directly, without synchronizing them, on the event cycle.
  assign strobe_evt = sync_p1 & ~sync_p2;
  assign qual_evt   = strobe_evt & ~SSER_n & ~BA13 & BA12 & BR_W;

  // Sample sequencer FSM
  state_t     state;
  state_t     state_nxt;
  logic [3:0] dly_cnt;
  logic       load_dly;
  logic       dec_dly;
  logic       sample_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // WAIT leaves when the decremented count reaches zero. As a result, the
  // SDRD sample lands exactly SAMPLE_DLY clocks after the event edge. With
  // SAMPLE_DLY=1 the FSM skips WAIT entirely.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (qual_evt) begin
          state_nxt = (SAMPLE_DLY == 1) ? S_SAMPLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (dly_cnt <= 4'd1) begin
          state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    load_dly  = 1'b0;
    dec_dly   = 1'b0;
    sample_en = 1'b0;
    unique case (state)
      S_IDLE:   load_dly  = qual_evt;
      S_WAIT:   dec_dly   = 1'b1;
      S_SAMPLE: sample_en = 1'b1;
      default: begin
        load_dly  = 1'b0;
        dec_dly   = 1'b0;
        sample_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt <= 4'd0;
    end else if (clr) begin
      dly_cnt <= 4'd0;
    end else if (load_dly) begin
      dly_cnt <= DLY_LOAD;
    end else if (dec_dly) begin
      dly_cnt <= dly_cnt - 4'd1;
    end
  end

  // A qualified edge that arrives while a sample is pending is dropped.
  // The pending sample keeps its original timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collide <= 1'b0;
    end else if (clr) begin
      collide <= 1'b0;
    end else if (qual_evt && (state != S_IDLE)) begin
      collide <= 1'b1;
    end
  end

  // Bit assembly
  logic [7:0] shreg;
  logic       push;
  logic [7:0] push_word;

  assign push      = sample_en & (bit_count == 3'd7);
  assign push_word = {shreg[6:0], SDRD};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= 8'h00;
      bit_count <= 3'd0;
    end else if (clr) begin
      shreg     <= 8'h00;
      bit_count <= 3'd0;
    end else if (sample_en) begin
      shreg     <= push_word;
      bit_count <= bit_count + 3'd1;  // 7 -> 0 wrap marks the completed byte
    end
  end

  // Output buffer: 2-entry FIFO
  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       full;
  logic       pop;
  logic       do_write;
  logic       drop;

  assign full      = (count == 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  // When the buffer is full and popped in the same cycle, wr_ptr equals
  // rd_ptr. The new byte then takes over the slot that is being vacated.
  assign do_write  = push & (~full | pop);
  assign drop      = push & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= 8'h00;
      mem[1] <= 8'h00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clr) begin
      mem[0] <= 8'h00;
      mem[1] <= 8'h00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_write) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({do_write, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_key_bit_collector.sv
module tb_key_bit_collector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bus_strobe = 1'b0;
  logic       SSER_n = 1'b1;
  logic       BA13 = 1'b0;
  logic       BA12 = 1'b0;
  logic       BR_W = 1'b0;
  logic       SDRD = 1'b0;
  logic       clr = 1'b0;
  logic       out_ready = 1'b0;

  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] bit_count;
  logic       overflow;
  logic       collide;

  logic [7:0] out_data4;
  logic       out_valid4;
  logic [2:0] bit_count4;
  logic       overflow4;
  logic       collide4;

  int errors = 0;
  int checks = 0;

  logic [2:0] cap_bc;
  logic       cap_vld;
  logic [7:0] cap_data;

  always #5 clk = ~clk;

  key_bit_collector #(.SAMPLE_DLY(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus_strobe(bus_strobe), .SSER_n(SSER_n),
    .BA13(BA13), .BA12(BA12), .BR_W(BR_W), .SDRD(SDRD), .clr(clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .bit_count(bit_count), .overflow(overflow), .collide(collide)
  );

  key_bit_collector #(.SAMPLE_DLY(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus_strobe(bus_strobe), .SSER_n(SSER_n),
    .BA13(BA13), .BA12(BA12), .BR_W(BR_W), .SDRD(SDRD), .clr(clr),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .bit_count(bit_count4), .overflow(overflow4), .collide(collide4)
  );

  typedef struct {
    logic       sser;
    logic       ba13;
    logic       ba12;
    logic       brw;
    logic       sdrd;
    logic       glitch;
    logic [2:0] exp_bc;
    logic       exp_vld;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic sser, logic ba13, logic ba12, logic brw,
                              logic sdrd, logic glitch, logic [2:0] bc,
                              logic vld, logic [7:0] data);
    vec_t v;
    v.sser = sser; v.ba13 = ba13; v.ba12 = ba12; v.brw = brw;
    v.sdrd = sdrd; v.glitch = glitch;
    v.exp_bc = bc; v.exp_vld = vld; v.exp_data = data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus read cycle. The strobe rises before edge N, and the SAMPLE_DLY=2
  // instance samples SDRD at edge N+4. With glitch set, SDRD carries the
  // inverted bit everywhere except around that edge. The outputs of the
  // SAMPLE_DLY=2 instance are captured just after the sample edge.
  task automatic do_read(input logic sser, input logic b13, input logic b12,
                         input logic brw, input logic bv, input logic glitch,
                         input logic rdy_pulse, input logic clr_at);
    @(negedge clk);
    SSER_n = sser; BA13 = b13; BA12 = b12; BR_W = brw;
    SDRD = glitch ? ~bv : bv;
    bus_strobe = 1'b1;
    repeat (4) @(negedge clk);
    SDRD = bv;
    if (rdy_pulse) out_ready = 1'b1;
    if (clr_at) clr = 1'b1;
    @(negedge clk);
    cap_bc = bit_count; cap_vld = out_valid; cap_data = out_data;
    SDRD = glitch ? ~bv : bv;
    if (rdy_pulse) out_ready = 1'b0;
    clr = 1'b0;
    bus_strobe = 1'b0;
    repeat (3) @(negedge clk);
    SSER_n = 1'b1; BA13 = 1'b0; BA12 = 1'b0; BR_W = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy_last);
    for (int i = 7; i >= 0; i--) begin
      do_read(1'b0, 1'b0, 1'b1, 1'b1, b[i], 1'b1, rdy_last && (i == 0), 1'b0);
    end
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Byte A5 with glitching SDRD, then the four disqualified reads, then
    // one qualified read.
    vecs[0]  = mk(0, 0, 1, 1, 1, 1, 3'd1, 0, 8'h00);
    vecs[1]  = mk(0, 0, 1, 1, 0, 1, 3'd2, 0, 8'h00);
    vecs[2]  = mk(0, 0, 1, 1, 1, 1, 3'd3, 0, 8'h00);
    vecs[3]  = mk(0, 0, 1, 1, 0, 1, 3'd4, 0, 8'h00);
    vecs[4]  = mk(0, 0, 1, 1, 0, 1, 3'd5, 0, 8'h00);
    vecs[5]  = mk(0, 0, 1, 1, 1, 1, 3'd6, 0, 8'h00);
    vecs[6]  = mk(0, 0, 1, 1, 0, 1, 3'd7, 0, 8'h00);
    vecs[7]  = mk(0, 0, 1, 1, 1, 1, 3'd0, 1, 8'hA5);
    vecs[8]  = mk(1, 0, 1, 1, 1, 0, 3'd0, 0, 8'h00);
    vecs[9]  = mk(0, 1, 1, 1, 1, 0, 3'd0, 0, 8'h00);
    vecs[10] = mk(0, 0, 0, 1, 1, 0, 3'd0, 0, 8'h00);
    vecs[11] = mk(0, 0, 1, 0, 1, 0, 3'd0, 0, 8'h00);
    vecs[12] = mk(0, 0, 1, 1, 1, 0, 3'd1, 0, 8'h00);

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_in_bc", {5'd0, bit_count}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_data", out_data, 8'h00);
    chk("rst_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_bc", {5'd0, bit_count}, 8'h00);
    chk("rst_ovf", {7'd0, overflow}, 8'h00);
    chk("rst_col", {7'd0, collide}, 8'h00);

    // Byte assembly and qualification
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      do_read(vecs[i].sser, vecs[i].ba13, vecs[i].ba12, vecs[i].brw,
              vecs[i].sdrd, vecs[i].glitch, 1'b0, 1'b0);
      chk($sformatf("vec%0d_bc", i), {5'd0, cap_bc}, {5'd0, vecs[i].exp_bc});
      chk($sformatf("vec%0d_vld", i), {7'd0, cap_vld}, {7'd0, vecs[i].exp_vld});
      if (vecs[i].exp_vld) chk($sformatf("vec%0d_data", i), cap_data, vecs[i].exp_data);
    end
    out_ready = 1'b0;

    // Buffer overflow with out_ready low
    clr_pulse();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    chk("buf2_ovf", {7'd0, overflow}, 8'h00);
    send_byte(8'h33, 1'b0);
    chk("buf3_ovf", {7'd0, overflow}, 8'h01);
    chk("buf3_data", out_data, 8'h11);
    pop_one();
    chk("pop1_vld", {7'd0, out_valid}, 8'h01);
    chk("pop1_data", out_data, 8'h22);
    pop_one();
    chk("pop2_vld", {7'd0, out_valid}, 8'h00);

    // Full buffer, push and pop on the same edge
    clr_pulse();
    chk("clr_ovf", {7'd0, overflow}, 8'h00);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    chk("full_data", out_data, 8'h11);
    send_byte(8'h33, 1'b1);
    chk("pp_ovf", {7'd0, overflow}, 8'h00);
    chk("pp_data", out_data, 8'h22);
    pop_one();
    chk("pp_pop1_vld", {7'd0, out_valid}, 8'h01);
    chk("pp_pop1_data", out_data, 8'h33);
    pop_one();
    chk("pp_pop2_vld", {7'd0, out_valid}, 8'h00);

    // Collision: events two clocks apart
    clr_pulse();
    chk("col_clr4", {7'd0, collide4}, 8'h00);
    @(negedge clk);
    SSER_n = 1'b0; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b1; SDRD = 1'b1;
    bus_strobe = 1'b1;
    @(negedge clk);
    bus_strobe = 1'b0;
    @(negedge clk);
    bus_strobe = 1'b1;
    repeat (8) @(negedge clk);
    bus_strobe = 1'b0;
    repeat (4) @(negedge clk);
    SSER_n = 1'b1; BA12 = 1'b0; BR_W = 1'b0;
    chk("col4_flag", {7'd0, collide4}, 8'h01);
    chk("col4_bc", {5'd0, bit_count4}, 8'h01);
    chk("col4_vld", {7'd0, out_valid4}, 8'h00);
    chk("col4_ovf", {7'd0, overflow4}, 8'h00);
    chk("col4_data", out_data4, 8'h00);
    chk("col2_flag", {7'd0, collide}, 8'h01);
    chk("col2_bc", {5'd0, bit_count}, 8'h01);

    // Clear coinciding with a sample, then reset mid-word
    clr_pulse();
    chk("clr_col", {7'd0, collide}, 8'h00);
    do_read(0, 0, 1, 1, 1, 0, 0, 0);
    do_read(0, 0, 1, 1, 0, 0, 0, 0);
    do_read(0, 0, 1, 1, 1, 0, 0, 0);
    do_read(0, 0, 1, 1, 1, 0, 0, 0);
    do_read(0, 0, 1, 1, 0, 0, 0, 0);
    chk("mid5_bc", {5'd0, bit_count}, 8'h05);
    do_read(0, 0, 1, 1, 1, 0, 0, 1);
    chk("clr_sample_bc", {5'd0, bit_count}, 8'h00);
    do_read(0, 0, 1, 1, 1, 0, 0, 0);
    do_read(0, 0, 1, 1, 1, 0, 0, 0);
    do_read(0, 0, 1, 1, 1, 0, 0, 0);
    chk("mid3_bc", {5'd0, bit_count}, 8'h03);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_bc", {5'd0, bit_count}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_vld", {7'd0, out_valid}, 8'h00);
    send_byte(8'h3C, 1'b0);
    chk("clean_vld", {7'd0, out_valid}, 8'h01);
    chk("clean_data", out_data, 8'h3C);
    chk("clean_bc", {5'd0, bit_count}, 8'h00);
    chk("clean_ovf", {7'd0, overflow}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_bit_collector.md
# key_bit_collector

Downstream consumer of the key-chip serial output. It watches the host bus for qualified key-window read cycles (SSER_n=0, BA13=0, BA12=1, BR_W=1) and samples the SDRD data bit a fixed number of clocks into each cycle. It assembles the bits MSB-first into 8-bit words and hands completed words to the host-side controller through a 2-entry valid/ready buffer.

## Interface
- SAMPLE_DLY, 2: clocks from the detected strobe edge to the SDRD sample; legal range 1..15.
- clk  in  1  system clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bus_strobe  in  1  asynchronous bus-cycle strobe, active high; qualifiers must be stable while it is high.
- SSER_n  in  1  key-chip select, active low.
- BA13  in  1  bus address bit 13.
- BA12  in  1  bus address bit 12.
- BR_W  in  1  bus read/write; 1 means read.
- SDRD  in  1  key-chip serial data bit.
- clr  in  1  synchronous clear.
- out_data  out  8  oldest completed word.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word.
- bit_count  out  3  bits already shifted into the current partial word.
- overflow  out  1  sticky: a completed word was dropped.
- collide  out  1  sticky: a qualified edge arrived while a sample was still pending.

## Operation
- bus_strobe passes through a 2-flop synchronizer. A rising edge on the synchronized signal produces a one-cycle event.
- Qualification: on the event cycle, SSER_n, BA13, BA12 and BR_W are sampled directly.
- The event is qualified only when SSER_n=0, BA13=0, BA12=1 and BR_W=1. Unqualified events are ignored.
- FSM states:
  - IDLE: a qualified event loads dly_cnt=SAMPLE_DLY-1 and moves to WAIT.
  - WAIT: dly_cnt decrements each cycle. When dly_cnt=0, go to SAMPLE.
  - SAMPLE: shreg <= {shreg[6:0], SDRD}, bit_count increments, then return to IDLE.
- A qualified event that arrives in WAIT or SAMPLE is dropped and sets collide. Timing of the pending sample is unchanged.
- Word completion: when SAMPLE shifts in the 8th bit (bit_count=7), the assembled byte {shreg[6:0], SDRD} is pushed into the buffer and bit_count wraps to 0.
- Buffer behaviour:
  - 2-entry FIFO.
  - A pop occurs when out_valid & out_ready.
  - A push into a full buffer is allowed if a pop happens in the same cycle; the count stays at 2 and there is no overflow.
  - A push into a full buffer with no pop drops the word and sets overflow.
- clr clears shreg, bit_count, the FSM (to IDLE), dly_cnt, the buffer, overflow and collide. clr has priority over any event, sample, push or pop in the same cycle.
- Reset values: out_data=8'h00, out_valid=0, bit_count=0, overflow=0, collide=0, FSM=IDLE, synchronizer flops=0.
- Asserting rst_n low mid-word or mid-WAIT discards all partial state immediately.

## Timing
- bus_strobe rising before clk edge N gives the event at edge N+2 (2 synchronizer stages, then edge detect against the previous synced value).
- The sample happens on edge N+2+SAMPLE_DLY. For SAMPLE_DLY=1, WAIT lasts 0 cycles and the FSM goes straight to SAMPLE.
- A word-completing sample pushes at edge S. out_valid is high after S when the buffer was empty; out_data is the new word from the same edge.
- Pop takes effect at the accepting edge. The next entry, if any, is presented after that same edge.
- The minimum qualified-strobe spacing without collide is SAMPLE_DLY+1 clocks between events.

## Test plan
- Reset sequence: rst_n low for 3 cycles, then high. Required: all outputs at their reset values, out_valid=0.
- Byte assembly, SAMPLE_DLY=2, out_ready=1: eight qualified reads with SDRD held per read to 1,0,1,0,0,1,0,1. Required: out_valid pulses with out_data=8'hA5; bit_count returns to 0; SDRD toggled outside the sample edge has no effect.
- Qualification: reads with BA12=0, BA13=1, SSER_n=1 or BR_W=0, each with SDRD=1. Required: bit_count unchanged, no word.
- Buffer and overflow, out_ready=0: three complete bytes 8'h11, 8'h22, 8'h33. Required:
  - overflow=1.
  - Popping returns 8'h11, then 8'h22, then out_valid=0.
  - Repeating with out_ready asserted on the third push cycle leaves overflow=0 and returns 8'h11, 8'h22, 8'h33.
- Collision, SAMPLE_DLY=4: a second qualified event 2 clocks after the first. Required: collide=1, exactly one bit shifted.
- Clear and reset mid-word: after 5 bits, assert clr in the same cycle as a sample. Required: bit_count=0, no shift. Then 3 bits, then rst_n low for 1 cycle. Required: bit_count=0, out_valid=0; the next 8 bits form a clean word.
